// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter with 1-entry buffer per port; round-robin or fixed priority.
// Accepted writes reach the write port the next cycle; reqN_ready drops while bufN is full and not granted.
module regfile_write_arbiter #(
  parameter int PRIO_MODE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_data,
  output logic        RegWrite,
  output logic [4:0]  Write_register,
  output logic [31:0] Write_data,
  output logic        grant_id,
  output logic [15:0] wr_count
);

  logic        buf0_vld_q, buf0_vld_d;
  logic [4:0]  buf0_addr_q, buf0_addr_d;
  logic [31:0] buf0_data_q, buf0_data_d;
  logic        buf1_vld_q, buf1_vld_d;
  logic [4:0]  buf1_addr_q, buf1_addr_d;
  logic [31:0] buf1_data_q, buf1_data_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] wr_count_q, wr_count_d;

  logic gnt_vld;
  logic gnt_sel;
  logic xfer0;
  logic xfer1;

  // Arbitration and write port; everything is forced idle while reset is low.
  always_comb begin
    gnt_vld = reset & (buf0_vld_q | buf1_vld_q);
    if (PRIO_MODE == 1) begin
      gnt_sel = ~buf0_vld_q;
    end else if (buf0_vld_q && buf1_vld_q) begin
      gnt_sel = ~last_grant_q;
    end else begin
      gnt_sel = buf1_vld_q;
    end

    req0_ready = reset & (~buf0_vld_q | (gnt_vld & ~gnt_sel));
    req1_ready = reset & (~buf1_vld_q | (gnt_vld & gnt_sel));

    Write_register = 5'd0;
    Write_data     = 32'd0;
    grant_id       = 1'b0;
    if (gnt_vld) begin
      grant_id       = gnt_sel;
      Write_register = gnt_sel ? buf1_addr_q : buf0_addr_q;
      Write_data     = gnt_sel ? buf1_data_q : buf0_data_q;
    end
    RegWrite = gnt_vld & (Write_register != 5'd0);
    wr_count = wr_count_q;
  end

  always_comb begin
    xfer0 = req0_valid & req0_ready;
    xfer1 = req1_valid & req1_ready;

    buf0_vld_d  = buf0_vld_q;
    buf0_addr_d = buf0_addr_q;
    buf0_data_d = buf0_data_q;
    buf1_vld_d  = buf1_vld_q;
    buf1_addr_d = buf1_addr_q;
    buf1_data_d = buf1_data_q;

    // A granted buffer drains unless a same-edge transfer refills it.
    if (gnt_vld && !gnt_sel) buf0_vld_d = 1'b0;
    if (gnt_vld && gnt_sel)  buf1_vld_d = 1'b0;
    if (xfer0) begin
      buf0_vld_d  = 1'b1;
      buf0_addr_d = req0_addr;
      buf0_data_d = req0_data;
    end
    if (xfer1) begin
      buf1_vld_d  = 1'b1;
      buf1_addr_d = req1_addr;
      buf1_data_d = req1_data;
    end

    last_grant_d = gnt_vld ? gnt_sel : last_grant_q;
    wr_count_d   = (RegWrite && (wr_count_q != 16'hFFFF)) ? wr_count_q + 16'd1 : wr_count_q;

    // last_grant=1 so requester 0 wins the first contention after reset.
    if (!reset) begin
      buf0_vld_d   = 1'b0;
      buf0_addr_d  = 5'd0;
      buf0_data_d  = 32'd0;
      buf1_vld_d   = 1'b0;
      buf1_addr_d  = 5'd0;
      buf1_data_d  = 32'd0;
      last_grant_d = 1'b1;
      wr_count_d   = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    buf0_vld_q   <= buf0_vld_d;
    buf0_addr_q  <= buf0_addr_d;
    buf0_data_q  <= buf0_data_d;
    buf1_vld_q   <= buf1_vld_d;
    buf1_addr_q  <= buf1_addr_d;
    buf1_data_q  <= buf1_data_d;
    last_grant_q <= last_grant_d;
    wr_count_q   <= wr_count_d;
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: round-robin and fixed-priority instances share stimulus.
module tb_regfile_write_arbiter;

  typedef struct packed {
    logic        r0;
    logic        r1;
    logic        rw;
    logic        gid;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [15:0] cnt;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;

  logic        rr_r0, rr_r1, rr_rw, rr_gid;
  logic [4:0]  rr_wa;
  logic [31:0] rr_wd;
  logic [15:0] rr_cnt;
  logic        pr_r0, pr_r1, pr_rw, pr_gid;
  logic [4:0]  pr_wa;
  logic [31:0] pr_wd;
  logic [15:0] pr_cnt;

  int   vectors;
  int   miscompares;
  exp_t sb[$];

  regfile_write_arbiter #(.PRIO_MODE(0)) dut_rr (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(rr_r0), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(rr_r1), .req1_addr(req1_addr), .req1_data(req1_data),
    .RegWrite(rr_rw), .Write_register(rr_wa), .Write_data(rr_wd),
    .grant_id(rr_gid), .wr_count(rr_cnt)
  );

  regfile_write_arbiter #(.PRIO_MODE(1)) dut_pr (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(pr_r0), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(pr_r1), .req1_addr(req1_addr), .req1_data(req1_data),
    .RegWrite(pr_rw), .Write_register(pr_wa), .Write_data(pr_wd),
    .grant_id(pr_gid), .wr_count(pr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic r0, input logic r1, input logic rw, input logic gid,
                              input logic [4:0] wa, input logic [31:0] wd, input logic [15:0] cnt);
    exp_t e;
    e.r0 = r0; e.r1 = r1; e.rw = rw; e.gid = gid; e.wa = wa; e.wd = wd; e.cnt = cnt;
    return e;
  endfunction

  function automatic exp_t idle(input logic [15:0] cnt);
    return mk(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, cnt);
  endfunction

  function automatic exp_t in_rst(input logic [15:0] cnt);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, cnt);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, compare outputs at the falling edge.
  task automatic step(input string tag, input logic sel,
                      input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                      input exp_t e);
    exp_t x;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    sb.push_back(e);
    @(negedge clk);
    x = sb.pop_front();
    chk({tag, ".req0_ready"},     sel ? pr_r0  : rr_r0,  x.r0);
    chk({tag, ".req1_ready"},     sel ? pr_r1  : rr_r1,  x.r1);
    chk({tag, ".RegWrite"},       sel ? pr_rw  : rr_rw,  x.rw);
    chk({tag, ".grant_id"},       sel ? pr_gid : rr_gid, x.gid);
    chk({tag, ".Write_register"}, sel ? pr_wa  : rr_wa,  x.wa);
    chk({tag, ".Write_data"},     sel ? pr_wd  : rr_wd,  x.wd);
    chk({tag, ".wr_count"},       sel ? pr_cnt : rr_cnt, x.cnt);
    @(posedge clk);
    #1;
  endtask

  task automatic raw_reset();
    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int n;
    logic [15:0] cnt_at;
    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    req0_valid = 1'b0; req0_addr = 5'd0; req0_data = 32'd0;
    req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 32'd0;
    @(posedge clk);
    #1;

    // Reset state; valid offers during reset must see ready low.
    step("rst_idle", 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, in_rst(16'd0));
    step("rst_offer", 0, 1, 5'd9, 32'h99, 1, 5'd10, 32'hAA, in_rst(16'd0));
    reset = 1'b1;

    // Single write
    step("single_c0", 0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, idle(16'd0));
    step("single_c1", 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0,
         mk(1, 1, 1, 0, 5'd5, 32'hDEADBEEF, 16'd0));
    step("single_c2", 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, idle(16'd1));

    // Contention right after reset: req0 first, req1 re-offer blocked one cycle
    reset = 1'b0;
    step("cont_rst", 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, in_rst(16'd1));
    reset = 1'b1;
    step("cont_c0", 0, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, idle(16'd0));
    step("cont_c1", 0, 0, 5'd0, 32'd0, 1, 5'd3, 32'h33, mk(1, 0, 1, 0, 5'd1, 32'h11, 16'd0));
    step("cont_c2", 0, 0, 5'd0, 32'd0, 1, 5'd3, 32'h33, mk(1, 1, 1, 1, 5'd2, 32'h22, 16'd1));
    step("cont_c3", 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, mk(1, 1, 1, 1, 5'd3, 32'h33, 16'd2));
    step("cont_c4", 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, idle(16'd3));

    // Register-0 write drains without counting
    step("r0w_c0", 0, 0, 5'd0, 32'd0, 1, 5'd0, 32'hFFFFFFFF, idle(16'd3));
    step("r0w_c1", 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, mk(1, 1, 0, 1, 5'd0, 32'hFFFFFFFF, 16'd3));
    step("r0w_c2", 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, idle(16'd3));

    // Streaming: four items per requester, grants alternate starting with req0
    reset = 1'b0;
    step("strm_rst", 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, in_rst(16'd3));
    reset = 1'b1;
    step("strm_s0", 0, 1, 5'd16, 32'hA0, 1, 5'd24, 32'hB0, idle(16'd0));
    step("strm_s1", 0, 1, 5'd17, 32'hA1, 1, 5'd25, 32'hB1, mk(1, 0, 1, 0, 5'd16, 32'hA0, 16'd0));
    step("strm_s2", 0, 1, 5'd18, 32'hA2, 1, 5'd25, 32'hB1, mk(0, 1, 1, 1, 5'd24, 32'hB0, 16'd1));
    step("strm_s3", 0, 1, 5'd18, 32'hA2, 1, 5'd26, 32'hB2, mk(1, 0, 1, 0, 5'd17, 32'hA1, 16'd2));
    step("strm_s4", 0, 1, 5'd19, 32'hA3, 1, 5'd26, 32'hB2, mk(0, 1, 1, 1, 5'd25, 32'hB1, 16'd3));
    step("strm_s5", 0, 1, 5'd19, 32'hA3, 1, 5'd27, 32'hB3, mk(1, 0, 1, 0, 5'd18, 32'hA2, 16'd4));
    step("strm_s6", 0, 0, 5'd0, 32'd0, 1, 5'd27, 32'hB3, mk(0, 1, 1, 1, 5'd26, 32'hB2, 16'd5));
    step("strm_s7", 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, mk(1, 0, 1, 0, 5'd19, 32'hA3, 16'd6));
    step("strm_s8", 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, mk(1, 1, 1, 1, 5'd27, 32'hB3, 16'd7));
    step("strm_s9", 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, idle(16'd8));

    // Reset with both buffers full discards them
    step("mrst_fill", 0, 1, 5'd3, 32'h3, 1, 5'd4, 32'h4, idle(16'd8));
    reset = 1'b0;
    step("mrst_rst", 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, in_rst(16'd8));
    reset = 1'b1;
    step("mrst_c1", 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, idle(16'd0));
    step("mrst_c2", 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, idle(16'd0));

    // Fixed priority: req1 starves while req0 keeps offering
    raw_reset();
    step("prio_p0", 1, 1, 5'd1, 32'h100, 1, 5'd7, 32'h77, idle(16'd0));
    step("prio_p1", 1, 1, 5'd2, 32'h101, 1, 5'd8, 32'h88, mk(1, 0, 1, 0, 5'd1, 32'h100, 16'd0));
    step("prio_p2", 1, 1, 5'd3, 32'h102, 1, 5'd8, 32'h88, mk(1, 0, 1, 0, 5'd2, 32'h101, 16'd1));
    step("prio_p3", 1, 1, 5'd4, 32'h103, 1, 5'd8, 32'h88, mk(1, 0, 1, 0, 5'd3, 32'h102, 16'd2));
    step("prio_p4", 1, 0, 5'd0, 32'd0, 1, 5'd8, 32'h88, mk(1, 0, 1, 0, 5'd4, 32'h103, 16'd3));
    step("prio_p5", 1, 0, 5'd0, 32'd0, 1, 5'd8, 32'h88, mk(1, 1, 1, 1, 5'd7, 32'h77, 16'd4));
    step("prio_p6", 1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, mk(1, 1, 1, 1, 5'd8, 32'h88, 16'd5));
    step("prio_p7", 1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, idle(16'd6));

    // Saturation: req0 alone streams one write per cycle
    raw_reset();
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h5;
    n = 0;
    cnt_at = 16'd0;
    for (int i = 0; i < 65540; i++) begin
      @(negedge clk);
      if (n == 65534) cnt_at = rr_cnt;
      if (rr_rw) n++;
    end
    req0_valid = 1'b0;
    @(negedge clk);
    chk("sat.writes_seen", n, 32'd65539);
    chk("sat.count_before", {16'd0, cnt_at}, 32'h0000FFFE);
    chk("sat.count_held", {16'd0, rr_cnt}, 32'h0000FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
